// File: rtl/lpif_tx_pkg.sv
// Shared types and constants for the LPIF data-stream transmit path.
// Optional debug counter: define LPIF_DSTRM_TX_DEBUG_CNT_EN.
package lpif_tx_pkg;

    localparam int STATE_W  = 4;
    localparam int PROTID_W = 2;
    localparam int DATA_W   = 32;
    localparam int WORD_W   = 42;
    localparam int DELAY_W  = 16;
    localparam int CNT_W    = 16;
    localparam int LANE_W   = 40;

    // Bit positions of the side-band signals on the PHY lanes.
    localparam int MRK_BIT  = 39;
    localparam int STB_BIT  = 3;

    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'd0,
        SEQ_DELAY  = 2'd1,
        SEQ_ONLINE = 2'd2
    } seq_state_e;

    function automatic logic [WORD_W-1:0] pack_word(
        input logic [STATE_W-1:0]  state,
        input logic [PROTID_W-1:0] protid,
        input logic [DATA_W-1:0]   data,
        input logic                dvalid,
        input logic                crc,
        input logic                crc_valid,
        input logic                valid
    );
        return {valid, crc_valid, crc, dvalid, data, protid, state};
    endfunction

endpackage

// File: rtl/ll_tx_online_seq.sv
// Link-up sequencer: IDLE -> DELAY (programmable hold) -> ONLINE.
// Exposes the next state so the top can register outputs aligned with the state register.
module ll_tx_online_seq
    import lpif_tx_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               tx_online,
    input  logic [DELAY_W-1:0] delay_y_value,
    output seq_state_e         state,
    output seq_state_e         state_nxt
);

    logic [DELAY_W-1:0] dly_cnt;
    logic [DELAY_W-1:0] dly_cnt_nxt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= SEQ_IDLE;
            dly_cnt <= '0;
        end else begin
            state   <= state_nxt;
            dly_cnt <= dly_cnt_nxt;
        end
    end

    // NOTE: defaults first so no path through this block can infer a latch.
    always_comb begin
        state_nxt   = state;
        dly_cnt_nxt = dly_cnt;
        case (state)
            SEQ_IDLE: begin
                if (tx_online) begin
                    state_nxt   = SEQ_DELAY;
                    dly_cnt_nxt = delay_y_value;
                end
            end
            SEQ_DELAY: begin
                if (dly_cnt == '0) state_nxt = SEQ_ONLINE;
                else               dly_cnt_nxt = dly_cnt - 1'b1;
            end
            SEQ_ONLINE: state_nxt = SEQ_ONLINE;
            default:    state_nxt = SEQ_IDLE;
        endcase
        // Dropping the link request wins over every other transition.
        if (!tx_online) state_nxt = SEQ_IDLE;
    end

endmodule

// File: rtl/lpif_dstrm_master_tx.sv
// LPIF data-stream master transmitter: packs the LPIF word onto two 40-bit PHY lanes.
// Optional ONLINE-valid counter in the debug word: define LPIF_DSTRM_TX_DEBUG_CNT_EN.
module lpif_dstrm_master_tx
    import lpif_tx_pkg::*;
(
    input  logic                clk_wr,
    input  logic                rst_wr,
    input  logic                tx_online,
    input  logic [DELAY_W-1:0]  delay_y_value,
    input  logic                m_gen2_mode,
    input  logic                tx_mrk_userbit,
    input  logic                tx_stb_userbit,
    input  logic [STATE_W-1:0]  dstrm_state,
    input  logic [PROTID_W-1:0] dstrm_protid,
    input  logic [DATA_W-1:0]   dstrm_data,
    input  logic                dstrm_dvalid,
    input  logic                dstrm_crc,
    input  logic                dstrm_crc_valid,
    input  logic                dstrm_valid,
    output logic [LANE_W-1:0]   tx_phy0,
    output logic [LANE_W-1:0]   tx_phy1,
    output logic                tx_online_delay,
    output logic [31:0]         tx_dstrm_debug_status
);

    seq_state_e         state;
    seq_state_e         state_nxt;
    logic [1:0]         state_bits;
    logic [WORD_W-1:0]  word_nxt;
    logic               mrk_nxt;
    logic               stb_nxt;
    logic [LANE_W-1:0]  phy0_nxt;
    logic [LANE_W-1:0]  phy1_nxt;

    ll_tx_online_seq u_seq (
        .clk           (clk_wr),
        .rst           (rst_wr),
        .tx_online     (tx_online),
        .delay_y_value (delay_y_value),
        .state         (state),
        .state_nxt     (state_nxt)
    );

    assign state_bits = state;

    // Lanes are built from the next state so the registered outputs line up with the state register.
    always_comb begin
        word_nxt = '0;
        stb_nxt  = 1'b0;
        mrk_nxt  = 1'b0;
        case (state_nxt)
            SEQ_DELAY: begin
                stb_nxt = 1'b1;
                mrk_nxt = 1'b1;
            end
            SEQ_ONLINE: begin
                word_nxt = pack_word(dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid,
                                     dstrm_crc, dstrm_crc_valid, dstrm_valid);
                stb_nxt  = tx_stb_userbit;
                mrk_nxt  = tx_mrk_userbit;
            end
            default: ;
        endcase
        mrk_nxt = mrk_nxt & m_gen2_mode;

        phy0_nxt           = {1'b0, word_nxt[LANE_W-2:0]};
        phy0_nxt[MRK_BIT]  = mrk_nxt;
        phy1_nxt           = '0;
        phy1_nxt[2:0]      = word_nxt[WORD_W-1:LANE_W-1];
        phy1_nxt[STB_BIT]  = stb_nxt;
        phy1_nxt[MRK_BIT]  = mrk_nxt;
    end

    // NOTE: only plain control/data flops here, so every one of them is reset; there is no storage array.
    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            tx_phy0         <= '0;
            tx_phy1         <= '0;
            tx_online_delay <= 1'b0;
        end else begin
            tx_phy0         <= phy0_nxt;
            tx_phy1         <= phy1_nxt;
            tx_online_delay <= (state_nxt == SEQ_ONLINE);
        end
    end

`ifdef LPIF_DSTRM_TX_DEBUG_CNT_EN
    logic [CNT_W-1:0] cnt;

    // Counts valid flits actually presented on the lanes while ONLINE; saturates.
    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            cnt <= '0;
        end else if (state_nxt == SEQ_IDLE) begin
            cnt <= '0;
        end else if (state_nxt == SEQ_ONLINE && dstrm_valid && cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tx_dstrm_debug_status = {state_bits, tx_online_delay, 13'h0, cnt};
`else
    assign tx_dstrm_debug_status = {state_bits, tx_online_delay, 29'h0};
`endif

endmodule

// File: tb/tb_lpif_dstrm_master_tx.sv
// Self-checking bench for lpif_dstrm_master_tx: directed link-up scenarios plus random traffic
// against a model that tracks how long the link request has been held.
module tb_lpif_dstrm_master_tx;

    logic        clk_wr = 1'b0;
    logic        rst_wr;
    logic        tx_online;
    logic [15:0] delay_y_value;
    logic        m_gen2_mode;
    logic        tx_mrk_userbit;
    logic        tx_stb_userbit;
    logic [3:0]  dstrm_state;
    logic [1:0]  dstrm_protid;
    logic [31:0] dstrm_data;
    logic        dstrm_dvalid;
    logic        dstrm_crc;
    logic        dstrm_crc_valid;
    logic        dstrm_valid;
    logic [39:0] tx_phy0;
    logic [39:0] tx_phy1;
    logic        tx_online_delay;
    logic [31:0] tx_dstrm_debug_status;

    int checks = 0;
    int errors = 0;

    // Model: consecutive edges with the request high since the last drop/reset,
    // the delay captured when the run started, and the ONLINE valid count.
    int run    = 0;
    int mdelay = 0;
    int mcnt   = 0;

    always #5 clk_wr = ~clk_wr;

    lpif_dstrm_master_tx dut (
        .clk_wr                (clk_wr),
        .rst_wr                (rst_wr),
        .tx_online             (tx_online),
        .delay_y_value         (delay_y_value),
        .m_gen2_mode           (m_gen2_mode),
        .tx_mrk_userbit        (tx_mrk_userbit),
        .tx_stb_userbit        (tx_stb_userbit),
        .dstrm_state           (dstrm_state),
        .dstrm_protid          (dstrm_protid),
        .dstrm_data            (dstrm_data),
        .dstrm_dvalid          (dstrm_dvalid),
        .dstrm_crc             (dstrm_crc),
        .dstrm_crc_valid       (dstrm_crc_valid),
        .dstrm_valid           (dstrm_valid),
        .tx_phy0               (tx_phy0),
        .tx_phy1               (tx_phy1),
        .tx_online_delay       (tx_online_delay),
        .tx_dstrm_debug_status (tx_dstrm_debug_status)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare all outputs.
    task automatic step();
        int          phase;
        logic [41:0] w;
        logic        stb, mrk;
        logic [39:0] e0, e1;
        logic [31:0] edbg;
        @(posedge clk_wr);
        if (rst_wr || !tx_online) begin
            run  = 0;
            mcnt = 0;
        end else begin
            if (run == 0) mdelay = int'(delay_y_value);
            if (run < 1000000) run++;
        end
        if (run == 0)               phase = 0;
        else if (run <= mdelay + 1) phase = 1;
        else                        phase = 2;
        if (phase == 2 && dstrm_valid && mcnt < 65535) mcnt++;

        w   = (phase == 2) ? {dstrm_valid, dstrm_crc_valid, dstrm_crc, dstrm_dvalid,
                              dstrm_data, dstrm_protid, dstrm_state} : 42'h0;
        stb = (phase == 0) ? 1'b0 : (phase == 1) ? 1'b1 : tx_stb_userbit;
        mrk = ((phase == 0) ? 1'b0 : (phase == 1) ? 1'b1 : tx_mrk_userbit) & m_gen2_mode;
        e0  = {mrk, w[38:0]};
        e1  = {mrk, 35'h0, stb, w[41:39]};
`ifdef LPIF_DSTRM_TX_DEBUG_CNT_EN
        edbg = {2'(phase), phase == 2, 13'h0, 16'(mcnt)};
`else
        edbg = {2'(phase), phase == 2, 29'h0};
`endif
        #1;
        check("tx_phy0", 64'(tx_phy0), 64'(e0));
        check("tx_phy1", 64'(tx_phy1), 64'(e1));
        check("tx_online_delay", 64'(tx_online_delay), 64'(phase == 2));
        check("debug_status", 64'(tx_dstrm_debug_status), 64'(edbg));
    endtask

    // Cycles until ONLINE (0 if the bound expires) and DELAY-strobe cycles seen on the way.
    task automatic wait_online(output int lat, output int nstb);
        lat  = 0;
        nstb = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (tx_phy1[3] && !tx_online_delay) nstb++;
            if (tx_online_delay) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic randomize_payload();
        dstrm_state     = 4'($urandom);
        dstrm_protid    = 2'($urandom);
        dstrm_data      = $urandom;
        dstrm_dvalid    = 1'($urandom);
        dstrm_crc       = 1'($urandom);
        dstrm_crc_valid = 1'($urandom);
        dstrm_valid     = 1'($urandom);
    endtask

    initial begin
        int lat, nstb;
        rst_wr         = 1'b1;
        tx_online      = 1'b0;
        delay_y_value  = 16'd0;
        m_gen2_mode    = 1'b1;
        tx_mrk_userbit = 1'b1;
        tx_stb_userbit = 1'b1;
        randomize_payload();

        // Reset state, with random traffic present on the inputs.
        step();
        step();
        check("reset_phy0", 64'(tx_phy0), 64'h0);
        check("reset_debug", 64'(tx_dstrm_debug_status), 64'h0);
        rst_wr = 1'b0;
        step();

        // Link-up with delay 3: four strobe cycles, ONLINE on the fifth edge.
        delay_y_value = 16'd3;
        tx_online     = 1'b1;
        wait_online(lat, nstb);
        check("delay3_latency", 64'(lat), 64'd5);
        check("delay3_strobes", 64'(nstb), 64'd4);

        // Directed flit.
        dstrm_data   = 32'hDEADBEEF;
        dstrm_state  = 4'h3;
        dstrm_protid = 2'b01;
        dstrm_valid  = 1'b1;
        dstrm_dvalid = 1'b1;
        step();
        check("flit_word", 64'(tx_phy0[37:0]), 64'({32'hDEADBEEF, 2'b01, 4'h3}));
        check("flit_dvalid", 64'(tx_phy0[38]), 64'd1);
        check("flit_valid", 64'(tx_phy1[2]), 64'd1);

        // Marker gating by Gen2 mode.
        m_gen2_mode = 1'b0;
        step();
        check("gen1_mrk0", 64'(tx_phy0[39]), 64'd0);
        check("gen1_mrk1", 64'(tx_phy1[39]), 64'd0);
        m_gen2_mode = 1'b1;
        step();
        check("gen2_mrk0", 64'(tx_phy0[39]), 64'd1);
        check("gen2_mrk1", 64'(tx_phy1[39]), 64'd1);

        // Drop mid-DELAY with counter at 5, then reassert: full delay reloads.
        delay_y_value = 16'd10;
        tx_online     = 1'b0;
        step();
        tx_online = 1'b1;
        for (int i = 0; i < 6; i++) step();
        tx_online = 1'b0;
        step();
        check("drop_strobe", 64'(tx_phy1[3]), 64'd0);
        check("drop_word", 64'(tx_phy0), 64'h0);
        tx_online = 1'b1;
        wait_online(lat, nstb);
        check("reload_latency", 64'(lat), 64'd12);
        check("reload_strobes", 64'(nstb), 64'd11);

`ifdef LPIF_DSTRM_TX_DEBUG_CNT_EN
        // Saturation of the ONLINE valid counter, then clear on link drop.
        dstrm_valid = 1'b1;
        for (int i = 0; i < 70000; i++) step();
        check("cnt_saturated", 64'(tx_dstrm_debug_status[15:0]), 64'hFFFF);
        tx_online = 1'b0;
        step();
        check("cnt_cleared", 64'(tx_dstrm_debug_status[15:0]), 64'h0);
        tx_online = 1'b1;
        wait_online(lat, nstb);
`endif

        // One-cycle reset pulse while ONLINE, then zero delay.
        rst_wr = 1'b1;
        step();
        check("pulse_phy0", 64'(tx_phy0), 64'h0);
        check("pulse_phy1", 64'(tx_phy1), 64'h0);
        check("pulse_online", 64'(tx_online_delay), 64'h0);
        check("pulse_debug", 64'(tx_dstrm_debug_status), 64'h0);
        rst_wr        = 1'b0;
        delay_y_value = 16'd0;
        wait_online(lat, nstb);
        check("delay0_latency", 64'(lat), 64'd2);
        check("delay0_strobes", 64'(nstb), 64'd1);

        // Random traffic with occasional link drops and resets.
        for (int i = 0; i < 3000; i++) begin
            randomize_payload();
            tx_mrk_userbit = 1'($urandom);
            tx_stb_userbit = 1'($urandom);
            m_gen2_mode    = ($urandom_range(0, 9) != 0);
            delay_y_value  = 16'($urandom_range(0, 7));
            tx_online      = ($urandom_range(0, 39) != 0);
            rst_wr         = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
